// File: rtl/t1a_fs_pwm_top_if.sv
`default_nettype none
// ============================================================================
// Module   : t1a_fs_pwm_top_if
// Purpose  : Bundles the duty-code input and the three registered outputs of
//            the frequency-scaling / PWM block.
// Signals  : pulse_width [3:0] - duty code 0..15 (driven by master)
//            pwm_signal        - 500 Hz PWM output (driven by slave)
//            clk_500Hz         - 500 Hz frame square wave (driven by slave)
//            clk_1MHz          - 1 MHz square wave (driven by slave)
// Revision : 1.0 - initial release
// ============================================================================
interface t1a_fs_pwm_top_if;
   logic [3:0] pulse_width;
   logic       pwm_signal;
   logic       clk_500Hz;
   logic       clk_1MHz;

   modport master (
      output pulse_width,
      input  pwm_signal,
      input  clk_500Hz,
      input  clk_1MHz
   );

   modport slave (
      input  pulse_width,
      output pwm_signal,
      output clk_500Hz,
      output clk_1MHz
   );
endinterface
`default_nettype wire

// File: rtl/t1a_fs_pwm_top.sv
`default_nettype none
// ============================================================================
// Module   : t1a_fs_pwm_top
// Purpose  : Divides the 50 MHz system clock into a 1 MHz square wave and a
//            500 Hz frame clock, and generates a 500 Hz PWM whose high time is
//            pulse_width x SLOT_US microseconds. Everything runs on clk_50MHz;
//            the divided clocks are outputs only, internal timing uses a
//            one-cycle tick enable.
// Ports    : clk_50MHz - system clock, rising edge
//            rst_n     - asynchronous active-low reset
//            bus       - slave modport: pulse_width in; pwm_signal,
//                        clk_500Hz, clk_1MHz out (all outputs registered)
// Revision : 1.0 - initial release
// ============================================================================
module t1a_fs_pwm_top #(
   parameter int unsigned CLK_DIV       = 50,    // clk cycles per 1 us tick
   parameter int unsigned PWM_PERIOD_US = 2000,  // ticks per PWM frame
   parameter int unsigned SLOT_US       = 125    // ticks per duty-code LSB
) (
   input  wire logic             clk_50MHz,
   input  wire logic             rst_n,
   t1a_fs_pwm_top_if.slave       bus
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned US_W  = (PWM_PERIOD_US > 1) ? $clog2(PWM_PERIOD_US) : 1;
   // One extra bit so us_cnt+1 and the high-time limit never overflow.
   localparam int unsigned CMP_W = US_W + 1;

   localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] c_DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);
   localparam logic [US_W-1:0]  c_US_LAST  = US_W'(PWM_PERIOD_US - 1);
   localparam logic [US_W-1:0]  c_US_HALF  = US_W'(PWM_PERIOD_US / 2 - 1);
   localparam logic [CMP_W-1:0] c_SLOT     = CMP_W'(SLOT_US);

   logic [DIV_W-1:0] r_div_cnt;
   logic [US_W-1:0]  r_us_cnt;
   logic [3:0]       r_pw_lat;
   logic             r_clk_1mhz;
   logic             r_clk_500hz;
   logic             r_pwm;

   logic             w_tick;
   logic             w_div_half;
   logic             w_frame_mid;
   logic             w_frame_end;
   logic [CMP_W-1:0] w_us_next;
   logic [CMP_W-1:0] w_high_lim;
   logic             w_pwm_next;

   assign w_tick      = (r_div_cnt == c_DIV_LAST);
   assign w_div_half  = (r_div_cnt == c_DIV_HALF);
   assign w_frame_mid = w_tick && (r_us_cnt == c_US_HALF);
   assign w_frame_end = w_tick && (r_us_cnt == c_US_LAST);

   // Position within the frame after this tick; the output is high while that
   // position is below the latched code times the slot length.
   assign w_us_next  = CMP_W'(r_us_cnt) + CMP_W'(1);
   assign w_high_lim = CMP_W'(r_pw_lat) * c_SLOT;
   assign w_pwm_next = (w_us_next < w_high_lim);

   // Prescaler and 1 MHz square wave (toggles at half and full prescale).
   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt  <= '0;
         r_clk_1mhz <= 1'b0;
      end else begin
         r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
         if (w_div_half || w_tick) begin
            r_clk_1mhz <= ~r_clk_1mhz;
         end
      end
   end

   // Microsecond counter and 500 Hz frame clock, both advanced by the tick.
   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_us_cnt    <= '0;
         r_clk_500hz <= 1'b0;
      end else if (w_tick) begin
         r_us_cnt <= w_frame_end ? '0 : r_us_cnt + US_W'(1);
         if (w_frame_mid || w_frame_end) begin
            r_clk_500hz <= ~r_clk_500hz;
         end
      end
   end

   // The duty code is captured only at the frame boundary so a mid-frame
   // change can never shorten or extend the pulse already in progress. The
   // boundary edge itself uses the fresh code directly so the pulse starts
   // coincident with the clk_500Hz falling edge.
   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_pw_lat <= '0;
         r_pwm    <= 1'b0;
      end else if (w_frame_end) begin
         r_pw_lat <= bus.pulse_width;
         r_pwm    <= |bus.pulse_width;
      end else if (w_tick) begin
         r_pwm <= w_pwm_next;
      end
   end

   assign bus.pwm_signal = r_pwm;
   assign bus.clk_500Hz  = r_clk_500hz;
   assign bus.clk_1MHz   = r_clk_1mhz;

endmodule
`default_nettype wire

// File: tb/tb_t1a_fs_pwm_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_t1a_fs_pwm_top
// Purpose  : Self-checking bench. A scaled instance (4 clk/us, 40 us frame,
//            2 us slot) exercises the full PWM behaviour; a default-parameter
//            instance on the same clock/reset checks the real 50 MHz timing
//            of clk_1MHz. Expected outputs are computed from elapsed edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_t1a_fs_pwm_top;

   localparam int SD = 4,  SP = 40,   SS = 2;    // scaled instance
   localparam int DD = 50, DP = 2000, DS = 125;  // default instance

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] pw = 4'd0;

   int n;            // rising edges since reset release
   int lat_s, lat_d; // duty code in force for the current frame
   int n_checks = 0;
   int n_fail   = 0;

   t1a_fs_pwm_top_if bus_s ();
   t1a_fs_pwm_top_if bus_d ();

   assign bus_s.pulse_width = pw;
   assign bus_d.pulse_width = pw;

   t1a_fs_pwm_top #(.CLK_DIV(SD), .PWM_PERIOD_US(SP), .SLOT_US(SS)) u_dut_s (
      .clk_50MHz (clk),
      .rst_n     (rst_n),
      .bus       (bus_s)
   );

   t1a_fs_pwm_top u_dut_d (
      .clk_50MHz (clk),
      .rst_n     (rst_n),
      .bus       (bus_d)
   );

   always #5 clk = ~clk;

   // Timeline model: elapsed edges plus the code sampled at each boundary.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n     <= 0;
         lat_s <= 0;
         lat_d <= 0;
      end else begin
         n <= n + 1;
         if ((n + 1) % (SD * SP) == 0) lat_s <= int'(pw);
         if ((n + 1) % (DD * DP) == 0) lat_d <= int'(pw);
      end
   end

   function automatic logic e_clk1(int e, int d);
      return (e % d) >= d / 2;
   endfunction

   function automatic logic e_clk500(int e, int d, int p);
      return ((e / d) % p) >= p / 2;
   endfunction

   function automatic logic e_pwm(int e, int d, int p, int s, int code);
      int t;
      t = e / d;
      return (t / p >= 1) && ((t % p) < code * s);
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b (edge %0d, t=%0t)", name, act, exp, n, $time);
      end
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      chk("s_clk_1MHz",   bus_s.clk_1MHz,   e_clk1(n, SD));
      chk("s_clk_500Hz",  bus_s.clk_500Hz,  e_clk500(n, SD, SP));
      chk("s_pwm_signal", bus_s.pwm_signal, e_pwm(n, SD, SP, SS, lat_s));
      chk("d_clk_1MHz",   bus_d.clk_1MHz,   e_clk1(n, DD));
      chk("d_clk_500Hz",  bus_d.clk_500Hz,  e_clk500(n, DD, DP));
      chk("d_pwm_signal", bus_d.pwm_signal, e_pwm(n, DD, DP, DS, lat_d));
   end

   task automatic wait_n(input int target);
      int guard;
      guard = 0;
      while (n != target && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      n_checks++;
      if (n != target) begin
         n_fail++;
         $display("FAIL wait_edge: got edge %0d expected edge %0d", n, target);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_s_pwm"},  bus_s.pwm_signal, 1'b0);
      chk({tag, "_s_500"},  bus_s.clk_500Hz,  1'b0);
      chk({tag, "_s_1M"},   bus_s.clk_1MHz,   1'b0);
      chk({tag, "_d_pwm"},  bus_d.pwm_signal, 1'b0);
      chk({tag, "_d_500"},  bus_d.clk_500Hz,  1'b0);
      chk({tag, "_d_1M"},   bus_d.clk_1MHz,   1'b0);
   endtask

   initial begin
      int tgt;
      // Reset with code 4 held from the start.
      pw    = 4'd4;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Hand-computed pins for the first frames.
      wait_n(2);   chk("lit_s_1M_rise",    bus_s.clk_1MHz,   1'b1);
      wait_n(4);   chk("lit_s_1M_fall",    bus_s.clk_1MHz,   1'b0);
      wait_n(24);  chk("lit_d_1M_e24",     bus_d.clk_1MHz,   1'b0);
      wait_n(25);  chk("lit_d_1M_e25",     bus_d.clk_1MHz,   1'b1);
      wait_n(49);  chk("lit_d_1M_e49",     bus_d.clk_1MHz,   1'b1);
      wait_n(50);  chk("lit_d_1M_e50",     bus_d.clk_1MHz,   1'b0);
      wait_n(75);  chk("lit_d_1M_e75",     bus_d.clk_1MHz,   1'b1);
      wait_n(79);  chk("lit_s_500_e79",    bus_s.clk_500Hz,  1'b0);
      wait_n(80);  chk("lit_s_500_e80",    bus_s.clk_500Hz,  1'b1);
      wait_n(159); chk("lit_s_pwm_e159",   bus_s.pwm_signal, 1'b0);
                   chk("lit_s_500_e159",   bus_s.clk_500Hz,  1'b1);
      wait_n(160); chk("lit_s_pwm_e160",   bus_s.pwm_signal, 1'b1);
                   chk("lit_s_500_e160",   bus_s.clk_500Hz,  1'b0);
      wait_n(191); chk("lit_s_pwm_e191",   bus_s.pwm_signal, 1'b1);
      wait_n(192); chk("lit_s_pwm_e192",   bus_s.pwm_signal, 1'b0);

      // Mid-frame change 4 -> 8: frame 1 keeps 8 ticks, frame 2 gets 16.
      wait_n(200); pw = 4'd8;
      wait_n(319); chk("lit_s_pwm_e319",   bus_s.pwm_signal, 1'b0);
      wait_n(320); chk("lit_s_pwm_e320",   bus_s.pwm_signal, 1'b1);
      wait_n(383); chk("lit_s_pwm_e383",   bus_s.pwm_signal, 1'b1);
      wait_n(384); chk("lit_s_pwm_e384",   bus_s.pwm_signal, 1'b0);

      // Codes 12 then 15 in successive frames.
      wait_n(400); pw = 4'd12;
      wait_n(575); chk("lit_s_pwm_c12_hi", bus_s.pwm_signal, 1'b1);
      wait_n(576); chk("lit_s_pwm_c12_lo", bus_s.pwm_signal, 1'b0);
      wait_n(600); pw = 4'd15;
      wait_n(759); chk("lit_s_pwm_c15_hi", bus_s.pwm_signal, 1'b1);
      wait_n(760); chk("lit_s_pwm_c15_lo", bus_s.pwm_signal, 1'b0);

      // Randomised codes, changed at arbitrary points inside frames.
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 39) == 0) pw = 4'($urandom_range(0, 15));
      end

      // Asynchronous reset in the middle of a code-8 pulse.
      pw  = 4'd8;
      tgt = (n / (SD * SP) + 1) * (SD * SP) + 5;
      wait_n(tgt);
      chk("pre_rst_pwm_high", bus_s.pwm_signal, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_rst");
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("rst_hold");
      rst_n = 1'b1;

      wait_n(25);  chk("rst2_d_1M_e25",    bus_d.clk_1MHz,   1'b1);
      wait_n(159); chk("rst2_s_pwm_e159",  bus_s.pwm_signal, 1'b0);
      wait_n(160); chk("rst2_s_pwm_e160",  bus_s.pwm_signal, 1'b1);
      wait_n(480);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
